// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the fetch stage and its neighbours.
package pipeline_pkg;

    typedef logic [31:0] instr_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    localparam int          DEFAULT_IMEM_ADDR_W = 9;
    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
    localparam instr_t      DEFAULT_NOP_INSTR   = 32'h0000_0000;

endpackage

// File: rtl/pc_npc_unit.sv
// PC/nPC pair with SPARC-style delayed branching: pc always advances to the
// old npc, so the delay-slot instruction is fetched before any branch target.
module pc_npc_unit
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] npc
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;

    // Branch-select mux; targets are accepted unchecked and fault later at pc.
    always_comb begin
        pc_d  = pc_q;
        npc_d = npc_q;
        if (load_en) begin
            pc_d  = npc_q;
            npc_d = branch_taken ? branch_target : (npc_q + 32'd4);
        end
    end

    // PC/nPC registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            npc_q <= RESET_PC + 32'd4;
        end else begin
            pc_q  <= pc_d;
            npc_q <= npc_d;
        end
    end

    assign pc  = pc_q;
    assign npc = npc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: drives the instruction-memory address, captures
// the IF/ID register, and halts with a sticky fault on a bad fetch address.
//
// state   | meaning
// RUN     | fetching normally
// HALT    | fetch fault taken; only reset leaves
module if_fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          IMEM_ADDR_W = DEFAULT_IMEM_ADDR_W,
    parameter instr_t      NOP_INSTR   = DEFAULT_NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_target,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [31:0]            imem_data,
    output logic [31:0]            ifid_instr,
    output logic [31:0]            ifid_pc,
    output logic                   ifid_valid,
    output logic [31:0]            pc_out,
    output logic [31:0]            npc_out,
    output logic                   fault,
    output logic [31:0]            fault_addr
);

    fetch_state_e state_q, state_d;
    instr_t       ifid_instr_q, ifid_instr_d;
    logic [31:0]  ifid_pc_q, ifid_pc_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic         fault_q, fault_d;
    logic [31:0]  fault_addr_q, fault_addr_d;

    logic [31:0]  pc;
    logic [31:0]  npc;
    logic         bad;
    logic         load_en;

    // Range/alignment check on the current pc; the top 4 bytes start at 508.
    assign bad = (pc[1:0] != 2'b00) || (pc[31:IMEM_ADDR_W] != '0);

    // A bad pc under stall simply waits; it faults on the first free edge.
    assign load_en = (state_q == ST_RUN) && !stall && !bad;

    pc_npc_unit #(
        .RESET_PC(RESET_PC)
    ) u_pc_npc (
        .clk          (clk),
        .reset        (reset),
        .load_en      (load_en),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .pc           (pc),
        .npc          (npc)
    );

    // Next-state and IF/ID capture; flush only squashes the captured word.
    always_comb begin
        state_d      = state_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    if (bad) begin
                        state_d      = ST_HALT;
                        fault_d      = 1'b1;
                        fault_addr_d = pc;
                        ifid_instr_d = NOP_INSTR;
                        ifid_valid_d = 1'b0;
                    end else begin
                        ifid_pc_d = pc;
                        if (flush) begin
                            ifid_instr_d = NOP_INSTR;
                            ifid_valid_d = 1'b0;
                        end else begin
                            ifid_instr_d = imem_data;
                            ifid_valid_d = 1'b1;
                        end
                    end
                end
            end
            ST_HALT: begin
                ifid_valid_d = 1'b0;
                fault_d      = 1'b1;
            end
            default: state_d = ST_HALT;
        endcase
    end

    // State, IF/ID and fault registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 32'd0;
            ifid_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign imem_addr  = pc[IMEM_ADDR_W-1:0];
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_valid = ifid_valid_q;
    assign pc_out     = pc;
    assign npc_out    = npc;
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

endmodule
